// File: rtl/ceas_pkg.sv
// Shared widths, wrap limits and the time record for the time-of-day counter.
package ceas_pkg;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned ORA_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [ORA_W-1:0] ORA_MAX = 5'd23;

  typedef struct packed {
    logic [ORA_W-1:0] ora;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } ceas_time_t;

  // Returns {carry, next}; any value at or above the limit wraps to 0.
  function automatic logic [6:0] inc_wrap6(input logic [5:0] v, input logic [5:0] lim);
    if (v >= lim) begin
      return {1'b1, 6'd0};
    end
    return {1'b0, v + 6'd1};
  endfunction

endpackage

// File: rtl/ceas_prescaler.sv
// Divides the system clock into a one-cycle tick every PRESCALE enabled cycles.
module ceas_prescaler #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by run so a pause in the last cycle holds the tick until resume.
  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/ceas_counter.sv
// Time-of-day counter (hh:mm:ss, 24 h) with load strobe and minute pulse.
// Optional load range check enabled by defining CEAS_LOAD_CHECK_EN.
module ceas_counter
  import ceas_pkg::*;
#(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [MIN_W-1:0] minute_setare,
  input  logic [ORA_W-1:0] ore_setare,
  output logic [SEC_W-1:0] secunde_counter,
  output logic [MIN_W-1:0] minute_counter,
  output logic [ORA_W-1:0] ore_counter,
  output logic             minute_pulse,
  output logic             load_err
);

  logic       tick;
  logic       load_ok;
  ceas_time_t time_q;
  ceas_time_t time_d;
  logic       pulse_q;
  logic       pulse_d;
  logic [6:0] sec_inc;
  logic [6:0] min_inc;

`ifdef CEAS_LOAD_CHECK_EN
  logic load_err_q;

  assign load_ok = load && (minute_setare <= MIN_MAX) && (ore_setare <= ORA_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load && !load_ok;
    end
  end

  assign load_err = load_err_q;
`else
  assign load_ok  = load;
  assign load_err = 1'b0;
`endif

  // A rejected load must leave the prescaler phase untouched, so clear follows load_ok.
  ceas_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .clear (load_ok),
    .tick  (tick)
  );

  always_comb begin
    sec_inc = inc_wrap6(time_q.sec, SEC_MAX);
    min_inc = inc_wrap6(time_q.min, MIN_MAX);
    time_d  = time_q;
    pulse_d = 1'b0;
    if (load_ok) begin
      time_d.ora = ore_setare;
      time_d.min = minute_setare;
      time_d.sec = '0;
    end else if (tick) begin
      time_d.sec = sec_inc[5:0];
      if (sec_inc[6]) begin
        pulse_d    = 1'b1;
        time_d.min = min_inc[5:0];
        if (min_inc[6]) begin
          time_d.ora = (time_q.ora >= ORA_MAX) ? '0 : time_q.ora + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      time_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      time_q  <= time_d;
      pulse_q <= pulse_d;
    end
  end

  assign secunde_counter = time_q.sec;
  assign minute_counter  = time_q.min;
  assign ore_counter     = time_q.ora;
  assign minute_pulse    = pulse_q;

endmodule

// File: doc/ceas_counter.md
# ceas_counter

Time-of-day counter feeding the alarm stage: divides the system clock into a 1 Hz tick and keeps seconds, minutes and hours in 24-hour format. Its `minute_counter`/`ore_counter` outputs connect directly to the alarm block's inputs of the same name. Current time is set from the UART command path through a load strobe. A one-cycle pulse marks every minute rollover for downstream display/alarm logic.

## Interface
- `PRESCALE`, default 50_000_000: clock cycles per second tick; must be ≥ 2.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = time advances; 0 = prescaler and counters frozen.
- `load`  in  1  one-cycle strobe; set current time from `minute_setare`/`ore_setare`.
- `minute_setare`  in  6  minutes to load, valid 0..59.
- `ore_setare`  in  5  hours to load, valid 0..23.
- `secunde_counter`  out  6  current seconds, 0..59.
- `minute_counter`  out  6  current minutes, 0..59.
- `ore_counter`  out  5  current hours, 0..23.
- `minute_pulse`  out  1  high for exactly one cycle when minutes change by counting; not on load.
- `load_err`  out  1  high for one cycle when a load was rejected; present only with `CEAS_LOAD_CHECK_EN`; tied 0 otherwise.

## Operation
- Prescaler: counts 0..PRESCALE-1 while `run`=1; at PRESCALE-1 it wraps to 0 and raises internal `tick` for that cycle. `run`=0 holds its value.
- On `tick`: seconds +1; 59→0 carries to minutes; minute 59→0 carries to hours; hour 23→0. 23:59:59 + tick → 00:00:00.
- `minute_pulse` = 1 in the cycle after the edge where seconds wrapped 59→0 (i.e., registered alongside the new minute value).
- Load: `minute_counter`←`minute_setare`, `ore_counter`←`ore_setare`, `secunde_counter`←0, prescaler←0. No `minute_pulse` on load.
- Load has priority over a coincident tick; the tick is discarded.
- Load is accepted regardless of `run`.
- Wrap comparisons use ≥ limit (seconds/minutes ≥ 59, hours ≥ 23), so any out-of-range value recovers to 0 on its next increment.
- Outputs never present 63 minutes/31 hours in normal operation, so the alarm block's disabled encoding never matches.

## Timing
- All outputs registered; reset values: all counters 0, `minute_pulse` 0, `load_err` 0, prescaler 0.
- Reset asserted mid-count clears everything immediately (asynchronous); first tick occurs PRESCALE cycles after the first edge with `reset`=1 and `run`=1.
- Load latency: outputs show loaded time one edge after the `load` edge.
- Tick latency: counters update on the edge where the prescaler equals PRESCALE-1.
- `run` falling in the tick cycle: the tick is suppressed and the prescaler holds at PRESCALE-1; the tick fires on the first edge after `run` returns.

## Configuration
- `CEAS_LOAD_CHECK_EN` defined: a load with `minute_setare` > 59 or `ore_setare` > 23 is ignored (time, seconds and prescaler unchanged) and `load_err` pulses for one cycle.
- Not defined: every load is applied as-is; `load_err` is constant 0; out-of-range values self-correct per the ≥ wrap rule.

## Structure
- Package `ceas_pkg`: `SEC_MAX`=59, `MIN_MAX`=59, `ORA_MAX`=23; widths `SEC_W`=6, `MIN_W`=6, `ORA_W`=5.
- Sub-module `ceas_prescaler` (parameter PRESCALE; ports clock, reset, run, clear, tick) generates the tick. The top contains the counters, load logic and pulses.

## Test plan
- Run `PRESCALE`=4, reset low then high, `run`=1 -> first `secunde_counter`=1 on the 4th edge; 0→1→2 every 4 cycles.
- Load 23:59 with `run`=1, wait 60 ticks -> outputs 00:00:00; one `minute_pulse`, none on the load itself.
- Load 12:34 in the same cycle as a tick -> 12:34:00, prescaler restarts, next tick is 4 cycles later.
- `run`=0 for 20 cycles mid-second -> no counter change; resuming completes the remaining cycles of the second exactly.
- With macro, load minute 60 or hour 24 -> time unchanged, `load_err` one cycle; without macro, 24:60 loaded, next minute carry → 00 hours/minutes per ≥ rule.
- Assert `reset` low while at 05:10:30 between edges -> outputs 0 immediately, without waiting for a clock edge.
